// File: rtl/banked_mem_responder.sv
// Memory-side responder with four word-interleaved 16-bit banks, a per-bank occupancy
// counter and a fixed-latency read return pipeline.
module banked_mem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int BANK_BUSY = 4,
    parameter int RD_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        rd_valid,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);

    localparam int         IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [2:0] BUSY_LOAD = 3'(BANK_BUSY - 1);

    // Handshake: a request is offered whenever exactly one of rd/wr is high with an
    // aligned address; it is taken in that cycle unless its bank is busy (stall), and
    // the requester must keep presenting a stalled request until it is taken.
    logic [1:0]       bank;
    logic [IDX_W-1:0] idx;
    logic             req_ok;
    logic             accept;
    logic             acc_rd;
    logic             acc_wr;

    logic [15:0] mem_q [4][MEM_WORDS];

    logic [2:0]  cnt_q [4];
    logic [2:0]  cnt_d [4];
    logic [3:0]  busy_q;
    logic [3:0]  busy_d;

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] vld_d;
    logic [15:0]       dat_q [RD_LAT];
    logic [15:0]       dat_d [RD_LAT];

    always_comb begin
        bank   = addr[2:1];
        idx    = IDX_W'(32'(addr[15:3]) % 32'(MEM_WORDS));
        err    = (rd & wr) | ((rd | wr) & addr[0]);
        req_ok = (rd ^ wr) & ~addr[0];
        stall  = req_ok & busy_q[bank];
        accept = req_ok & ~busy_q[bank];
        acc_rd = accept & rd;
        acc_wr = accept & wr;
    end

    // Occupancy counters: loading BANK_BUSY-1 keeps the bank busy for the following
    // BANK_BUSY-1 cycles, so it accepts again exactly BANK_BUSY cycles after the accept.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            cnt_d[b] = (cnt_q[b] != 3'd0) ? cnt_q[b] - 3'd1 : 3'd0;
            if (accept && (bank == 2'(b))) begin
                cnt_d[b] = BUSY_LOAD;
            end
            busy_d[b] = (cnt_d[b] != 3'd0);
        end
    end

    // Read word is sampled at accept, so later writes never disturb in-flight data.
    always_comb begin
        vld_d[0] = acc_rd;
        dat_d[0] = acc_rd ? mem_q[bank][idx] : 16'h0000;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 4'b0000;
            vld_q  <= '0;
            for (int b = 0; b < 4; b++) begin
                cnt_q[b] <= 3'd0;
            end
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= 16'h0000;
            end
        end else begin
            busy_q <= busy_d;
            vld_q  <= vld_d;
            for (int b = 0; b < 4; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    // Storage is deliberately outside the reset domain: contents survive a reset.
    always_ff @(posedge clk) begin
        if (acc_wr) begin
            mem_q[bank][idx] <= data_in;
        end
    end

    assign busy     = busy_q;
    assign rd_valid = vld_q[RD_LAT-1];
    assign data_out = dat_q[RD_LAT-1];

endmodule

// File: tb/tb_banked_mem_responder.sv
// Bench for banked_mem_responder: fixed vector table, hand-written corner sequences and
// randomized traffic, all checked against a cycle-indexed reference model.
module tb_banked_mem_responder;

    localparam int MEM_WORDS = 1024;
    localparam int BANK_BUSY = 4;
    localparam int RD_LAT    = 2;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        rd_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    banked_mem_responder #(
        .MEM_WORDS(MEM_WORDS),
        .BANK_BUSY(BANK_BUSY),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .data_in (data_in),
        .wr      (wr),
        .rd      (rd),
        .data_out(data_out),
        .rd_valid(rd_valid),
        .stall   (stall),
        .busy    (busy),
        .err     (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: word store, bank free times, expected read returns
    logic [15:0] mem_m [int];
    int          free_at [4];
    logic [15:0] exp_q [$];
    int          due_q [$];
    bit          known_q [$];
    int          cyc;

    int n_checks;
    int n_err;

    logic        s_stall;
    logic        s_err;
    logic        s_valid;
    logic [15:0] s_data;
    logic [3:0]  s_busy;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        exp_err;
        logic        exp_stall;
        logic        exp_valid;
        logic [15:0] exp_data;
    } vec_t;
    vec_t vq [$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int key_of(input logic [15:0] a);
        return int'(a[2:1]) * MEM_WORDS + (int'(a[15:3]) % MEM_WORDS);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 4; b++) free_at[b] = 0;
        exp_q.delete();
        due_q.delete();
        known_q.delete();
    endtask

    // driver: one request cycle, optionally with an asynchronous reset pulse mid-cycle
    task automatic step(input logic i_rd, input logic i_wr, input logic [15:0] i_addr,
                        input logic [15:0] i_din, input bit do_rst);
        logic        e_err;
        logic        e_stall;
        logic        e_valid;
        logic [15:0] e_data;
        bit          e_known;
        logic [3:0]  e_busy;
        int          b;
        int          k;
        rd      = i_rd;
        wr      = i_wr;
        addr    = i_addr;
        data_in = i_din;
        if (do_rst) begin
            #2 rst = 1'b1;
            #1 rst = 1'b0;
            model_reset();
        end
        @(negedge clk);
        b = int'(i_addr[2:1]);
        for (int j = 0; j < 4; j++) e_busy[j] = (cyc < free_at[j]);
        e_err   = (i_rd && i_wr) || ((i_rd || i_wr) && i_addr[0]);
        e_stall = (i_rd != i_wr) && !i_addr[0] && e_busy[b];
        e_valid = 1'b0;
        e_data  = 16'h0000;
        e_known = 1'b1;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            e_valid = 1'b1;
            e_data  = exp_q.pop_front();
            e_known = known_q.pop_front();
            void'(due_q.pop_front());
        end
        s_stall = stall;
        s_err   = err;
        s_valid = rd_valid;
        s_data  = data_out;
        s_busy  = busy;
        chk("m_err", {15'h0, err}, {15'h0, e_err});
        chk("m_stall", {15'h0, stall}, {15'h0, e_stall});
        chk("m_busy", {12'h0, busy}, {12'h0, e_busy});
        chk("m_rd_valid", {15'h0, rd_valid}, {15'h0, e_valid});
        if (e_known) chk("m_data_out", data_out, e_data);
        if ((i_rd != i_wr) && !i_addr[0] && !e_busy[b]) begin
            k = key_of(i_addr);
            free_at[b] = cyc + BANK_BUSY;
            if (i_wr) begin
                mem_m[k] = i_din;
            end else begin
                due_q.push_back(cyc + RD_LAT);
                known_q.push_back(mem_m.exists(k));
                exp_q.push_back(mem_m.exists(k) ? mem_m[k] : 16'h0000);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic add(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic ee, input logic es, input logic ev, input logic [15:0] ed);
        vec_t v;
        v.rd = r; v.wr = w; v.addr = a; v.din = d;
        v.exp_err = ee; v.exp_stall = es; v.exp_valid = ev; v.exp_data = ed;
        vq.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        cyc      = 0;
        rst      = 1'b1;
        rd       = 1'b0;
        wr       = 1'b0;
        addr     = 16'h0000;
        data_in  = 16'h0000;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {12'h0, busy}, 16'h0000);
        chk("reset_rd_valid", {15'h0, rd_valid}, 16'h0000);
        chk("reset_data_out", data_out, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b0;

        // write/read-back, line fill, eviction+fill, malformed requests
        add(0,1,16'h0000,16'h1234, 0,0,0,16'h0000);
        add(0,0,16'h0000,16'h0000, 0,0,0,16'h0000);
        add(0,0,16'h0000,16'h0000, 0,0,0,16'h0000);
        add(0,0,16'h0000,16'h0000, 0,0,0,16'h0000);
        add(1,0,16'h0000,16'h0000, 0,0,0,16'h0000);
        add(0,0,16'h0000,16'h0000, 0,0,0,16'h0000);
        add(0,0,16'h0000,16'h0000, 0,0,1,16'h1234);
        add(0,0,16'h0000,16'h0000, 0,0,0,16'h0000);
        add(0,1,16'h0010,16'h00A0, 0,0,0,16'h0000);
        add(0,1,16'h0012,16'h00A2, 0,0,0,16'h0000);
        add(0,1,16'h0014,16'h00A4, 0,0,0,16'h0000);
        add(0,1,16'h0016,16'h00A6, 0,0,0,16'h0000);
        add(1,0,16'h0010,16'h0000, 0,0,0,16'h0000);
        add(1,0,16'h0012,16'h0000, 0,0,0,16'h0000);
        add(1,0,16'h0014,16'h0000, 0,0,1,16'h00A0);
        add(1,0,16'h0016,16'h0000, 0,0,1,16'h00A2);
        add(0,1,16'h0100,16'h1111, 0,0,1,16'h00A4);
        add(0,1,16'h0102,16'h2222, 0,0,1,16'h00A6);
        add(0,1,16'h0104,16'h3333, 0,0,0,16'h0000);
        add(0,1,16'h0106,16'h4444, 0,0,0,16'h0000);
        add(1,0,16'h0100,16'h0000, 0,0,0,16'h0000);
        add(1,0,16'h0102,16'h0000, 0,0,0,16'h0000);
        add(1,0,16'h0104,16'h0000, 0,0,1,16'h1111);
        add(1,0,16'h0106,16'h0000, 0,0,1,16'h2222);
        add(0,0,16'h0000,16'h0000, 0,0,1,16'h3333);
        add(0,0,16'h0000,16'h0000, 0,0,1,16'h4444);
        add(0,1,16'h0004,16'h5555, 0,0,0,16'h0000);
        add(0,1,16'h0002,16'h6666, 0,0,0,16'h0000);
        add(1,1,16'h0004,16'hBEEF, 1,0,0,16'h0000);
        add(0,1,16'h0003,16'hFFFF, 1,0,0,16'h0000);
        add(1,0,16'h0004,16'h0000, 0,0,0,16'h0000);
        add(1,0,16'h0002,16'h0000, 0,0,0,16'h0000);
        add(0,0,16'h0000,16'h0000, 0,0,1,16'h5555);
        add(0,0,16'h0000,16'h0000, 0,0,1,16'h6666);
        add(0,0,16'h0000,16'h0000, 0,0,0,16'h0000);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rd, vq[i].wr, vq[i].addr, vq[i].din, 1'b0);
            chk("vec_err", {15'h0, s_err}, {15'h0, vq[i].exp_err});
            chk("vec_stall", {15'h0, s_stall}, {15'h0, vq[i].exp_stall});
            chk("vec_rd_valid", {15'h0, s_valid}, {15'h0, vq[i].exp_valid});
            chk("vec_data_out", s_data, vq[i].exp_data);
        end

        // same-bank conflict: second read held until the bank frees up
        idle(4);
        step(1'b0, 1'b1, 16'h0020, 16'h0C20, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 16'h0028, 16'h0C28, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
        chk("conf_first_stall", {15'h0, s_stall}, 16'h0000);
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, 16'h0028, 16'h0000, 1'b0);
            chk("conf_stall", {15'h0, s_stall}, 16'h0001);
            chk("conf_busy0", {15'h0, s_busy[0]}, 16'h0001);
            chk("conf_rd_valid", {15'h0, s_valid}, (k == 2) ? 16'h0001 : 16'h0000);
        end
        step(1'b1, 1'b0, 16'h0028, 16'h0000, 1'b0);
        chk("conf_accept_stall", {15'h0, s_stall}, 16'h0000);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("conf_gap_valid", {15'h0, s_valid}, 16'h0000);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("conf_second_valid", {15'h0, s_valid}, 16'h0001);
        chk("conf_second_data", s_data, 16'h0C28);

        // reset with a read in flight; storage must survive
        idle(3);
        step(1'b0, 1'b1, 16'h0040, 16'h4040, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        chk("rst_busy", {12'h0, s_busy}, 16'h0000);
        chk("rst_rd_valid", {15'h0, s_valid}, 16'h0000);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("rst_late_rd_valid", {15'h0, s_valid}, 16'h0000);
        chk("rst_late_data", s_data, 16'h0000);
        chk("rst_late_busy", {12'h0, s_busy}, 16'h0000);
        step(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
        chk("rst_reread_stall", {15'h0, s_stall}, 16'h0000);
        idle(1);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("rst_reread_valid", {15'h0, s_valid}, 16'h0001);
        chk("rst_reread_data", s_data, 16'h4040);

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            int          r;
            logic        rr;
            logic        ww;
            logic [15:0] a;
            r  = $urandom_range(0, 15);
            rr = (r < 5) || (r == 10);
            ww = (r >= 5 && r < 11);
            a  = {3'($urandom_range(0, 7)), 10'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0)};
            step(rr, ww, a, 16'($urandom), $urandom_range(0, 99) == 0);
        end
        idle(RD_LAT + 1);
        chk("drain_pending", 16'(due_q.size()), 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
